// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding used by the TX and RX state machines.
package uart_pkg;
   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

   // Rounded clock-per-oversample divisor, never below 1.
   function automatic int calc_div(input int clk_hz, input int baud);
      int d;
      d = (clk_hz + 8 * baud) / (16 * baud);
      return (d < 1) ? 1 : d;
   endfunction
endpackage

// File: rtl/uart_brg_if.sv
// Handshake and serial-line bundle between the UART and its host.
interface uart_brg_if;
   logic       ld_tx_req;
   logic       ld_tx_ack;
   logic [7:0] tx_data;
   logic       tx_enable;
   logic       tx_out;
   logic       tx_empty;
   logic       uld_rx_req;
   logic       uld_rx_ack;
   logic [7:0] rx_data;
   logic       rx_enable;
   logic       rx_in;
   logic       rx_empty;

   modport slave (
      input  ld_tx_req, tx_data, tx_enable, uld_rx_req, rx_enable, rx_in,
      output ld_tx_ack, tx_out, tx_empty, uld_rx_ack, rx_data, rx_empty
   );
   modport master (
      output ld_tx_req, tx_data, tx_enable, uld_rx_req, rx_enable, rx_in,
      input  ld_tx_ack, tx_out, tx_empty, uld_rx_ack, rx_data, rx_empty
   );
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running divider producing a one-clk oversample tick every DIV clocks.
module uart_baud_gen #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)            cnt <= '0;
      else if (cnt == LAST) cnt <= '0;
      else                  cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST);
endmodule

// File: rtl/uart_brg.sv
// 8N1 UART with 16x oversampling and four-phase load/unload handshakes.
// Define UART_RX_MAJORITY_EN to vote RX bits over oversamples 7/8/9.
module uart_brg
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 9600
) (
   input  logic      clk,
   input  logic      reset,
   uart_brg_if.slave bus
);
   localparam int DIV = calc_div(CLK_HZ, BAUD);
   localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);
   localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

   logic tick;

   uart_baud_gen #(.DIV(DIV)) u_baud (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // ---------------- transmitter ----------------
   uart_state_e tx_st, tx_nxt;
   logic [3:0]  tx_os;
   logic        bit_tick, tx_go;
   logic        hold_full, ld_ack, tx_out;
   logic [7:0]  hold_data, tx_sh;
   logic [2:0]  tx_cnt;

   assign bit_tick = tick && (tx_os == OS_LAST);

   always_comb begin
      tx_nxt = tx_st;
      tx_go  = 1'b0;
      case (tx_st)
         IDLE:  if (bit_tick && hold_full && bus.tx_enable) begin
                   tx_nxt = START;
                   tx_go  = 1'b1;
                end
         START: if (bit_tick) tx_nxt = DATA;
         DATA:  if (bit_tick && tx_cnt == BIT_LAST) tx_nxt = STOP;
         STOP:  if (bit_tick) tx_nxt = IDLE;
         default: tx_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_st     <= IDLE;
         tx_os     <= '0;
         hold_full <= 1'b0;
         hold_data <= '0;
         ld_ack    <= 1'b0;
         tx_out    <= 1'b1;
         tx_sh     <= '0;
         tx_cnt    <= '0;
      end else begin
         tx_st <= tx_nxt;
         if (tick) tx_os <= tx_os + 4'd1;
         if (bus.ld_tx_req && !ld_ack && !hold_full) begin
            hold_data <= bus.tx_data;
            hold_full <= 1'b1;
            ld_ack    <= 1'b1;
         end else if (!bus.ld_tx_req) begin
            ld_ack <= 1'b0;
         end
         // Load needs an empty holder and go needs a full one, so these never collide.
         if (tx_go) hold_full <= 1'b0;
         if (bit_tick) begin
            case (tx_st)
               IDLE:  if (tx_go) begin
                         tx_out <= 1'b0;
                         tx_sh  <= hold_data;
                      end
               START: begin
                         tx_out <= tx_sh[0];
                         tx_sh  <= {1'b1, tx_sh[7:1]};
                         tx_cnt <= '0;
                      end
               DATA:  if (tx_cnt == BIT_LAST) tx_out <= 1'b1;
                      else begin
                         tx_out <= tx_sh[0];
                         tx_sh  <= {1'b1, tx_sh[7:1]};
                         tx_cnt <= tx_cnt + 3'd1;
                      end
               default: tx_out <= 1'b1;
            endcase
         end
      end
   end

   assign bus.tx_out    = tx_out;
   assign bus.ld_tx_ack = ld_ack;
   assign bus.tx_empty  = !hold_full && (tx_st == IDLE);

   // ---------------- receiver ----------------
   uart_state_e rx_st, rx_nxt;
   logic        rx_s1, rx_s2, rx_s3, fall;
   logic [3:0]  rx_os;
   logic [2:0]  rx_cnt;
   logic [7:0]  rx_sh, rx_data;
   logic        bit_val, sample, rx_done, rx_shift;
   logic        rx_empty, uld_ack, unload;

`ifdef UART_RX_MAJORITY_EN
   localparam logic [3:0] SMP_OS = 4'd9;
   logic [1:0] smp;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) smp <= 2'b11;
      else if (tick && rx_os == 4'd7) smp[1] <= rx_s2;
      else if (tick && rx_os == 4'd8) smp[0] <= rx_s2;
   end

   assign bit_val = (smp[1] & smp[0]) | (smp[1] & rx_s2) | (smp[0] & rx_s2);
`else
   localparam logic [3:0] SMP_OS = 4'd8;
   assign bit_val = rx_s2;
`endif

   assign fall   = rx_s3 && !rx_s2;
   assign sample = tick && (rx_os == SMP_OS);
   assign unload = bus.uld_rx_req && !uld_ack;

   always_comb begin
      rx_nxt   = rx_st;
      rx_done  = 1'b0;
      rx_shift = 1'b0;
      if (rx_st != IDLE && tick && !bus.rx_enable) begin
         rx_nxt = IDLE;
      end else begin
         case (rx_st)
            IDLE:  if (bus.rx_enable && fall) rx_nxt = START;
            START: if (sample) rx_nxt = bit_val ? IDLE : DATA;
            DATA:  if (sample) begin
                      rx_shift = 1'b1;
                      if (rx_cnt == BIT_LAST) rx_nxt = STOP;
                   end
            STOP:  if (sample) begin
                      rx_nxt  = IDLE;
                      rx_done = bit_val;
                   end
            default: rx_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_s3    <= 1'b1;
         rx_st    <= IDLE;
         rx_os    <= '0;
         rx_cnt   <= '0;
         rx_sh    <= '0;
         rx_data  <= '0;
         rx_empty <= 1'b1;
         uld_ack  <= 1'b0;
      end else begin
         rx_s1 <= bus.rx_in;
         rx_s2 <= rx_s1;
         rx_s3 <= rx_s2;
         rx_st <= rx_nxt;
         // Oversample phase is anchored to the detected start edge.
         if (rx_st == IDLE) rx_os <= '0;
         else if (tick)     rx_os <= rx_os + 4'd1;
         if (rx_st == START) rx_cnt <= '0;
         if (rx_shift) begin
            rx_sh  <= {bit_val, rx_sh[7:1]};
            rx_cnt <= rx_cnt + 3'd1;
         end
         // An unload in the same cycle wins; the completing byte is then dropped.
         if (unload) begin
            uld_ack  <= 1'b1;
            rx_empty <= 1'b1;
         end else begin
            if (!bus.uld_rx_req) uld_ack <= 1'b0;
            if (rx_done && rx_empty) begin
               rx_data  <= rx_sh;
               rx_empty <= 1'b0;
            end
         end
      end
   end

   assign bus.rx_data    = rx_data;
   assign bus.rx_empty   = rx_empty;
   assign bus.uld_rx_ack = uld_ack;
endmodule

// File: tb/tb_uart_brg.sv
// Randomized bench for uart_brg at DIV=1 (one bit = 16 clk) with a line-level reference model.
module tb_uart_brg;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   logic       exp_empty;
   logic [7:0] exp_data;

   always #5 clk = ~clk;

   uart_brg_if bus();

   uart_brg #(.CLK_HZ(1600), .BAUD(100)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tx_load(input logic [7:0] d);
      bus.tx_data   = d;
      bus.ld_tx_req = 1'b1;
      @(negedge clk);
      chk("ld_ack_rise", bus.ld_tx_ack, 1);
      chk("tx_empty_drop", bus.tx_empty, 0);
      bus.ld_tx_req = 1'b0;
      @(negedge clk);
      chk("ld_ack_fall", bus.ld_tx_ack, 0);
   endtask

   // Decode one frame off tx_out: every bit must hold its level for exactly 16 clk.
   task automatic tx_capture(input logic [7:0] d);
      logic [9:0]  frame;
      logic [15:0] s;
      int w;
      frame = {1'b1, d, 1'b0};
      s = '0;
      w = 0;
      while (bus.tx_out !== 1'b0 && w < 80) begin
         @(negedge clk);
         w++;
      end
      chk("tx_start_seen", (w < 80), 1);
      if (w < 80) begin
         for (int i = 0; i < 160; i++) begin
            s[i % 16] = bus.tx_out;
            if (i % 16 == 15) chk($sformatf("tx_bit%0d", i / 16), s, {16{frame[i / 16]}});
            if (i < 159) @(negedge clk);
         end
         chk("tx_empty_in_stop", bus.tx_empty, 0);
         @(negedge clk);
         chk("tx_empty_after_stop", bus.tx_empty, 1);
      end
   endtask

   task automatic tx_send(input logic [7:0] d);
      fork
         tx_load(d);
         tx_capture(d);
      join
   endtask

   task automatic rx_frame(input logic [7:0] d, input logic stop);
      logic [9:0] f;
      logic       en;
      f  = {stop, d, 1'b0};
      en = bus.rx_enable;
      for (int b = 0; b < 10; b++) begin
         bus.rx_in = f[b];
         repeat (16) @(negedge clk);
      end
      bus.rx_in = 1'b1;
      repeat (6) @(negedge clk);
      if (en && stop && exp_empty) begin
         exp_data  = d;
         exp_empty = 1'b0;
      end
      chk($sformatf("rx_empty_%02h_%0d", d, stop), bus.rx_empty, exp_empty);
      chk($sformatf("rx_data_%02h_%0d", d, stop), bus.rx_data, exp_data);
   endtask

   task automatic rx_unload();
      bus.uld_rx_req = 1'b1;
      @(negedge clk);
      exp_empty = 1'b1;
      chk("uld_ack_rise", bus.uld_rx_ack, 1);
      chk("uld_rx_empty", bus.rx_empty, 1);
      chk("uld_data_hold", bus.rx_data, exp_data);
      bus.uld_rx_req = 1'b0;
      @(negedge clk);
      chk("uld_ack_fall", bus.uld_rx_ack, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] d;
      int z;
      reset          = 1'b1;
      bus.ld_tx_req  = 1'b0;
      bus.tx_data    = '0;
      bus.tx_enable  = 1'b1;
      bus.uld_rx_req = 1'b0;
      bus.rx_enable  = 1'b1;
      bus.rx_in      = 1'b1;
      exp_empty      = 1'b1;
      exp_data       = '0;
      repeat (3) @(negedge clk);
      chk("rst_tx_out", bus.tx_out, 1);
      chk("rst_tx_empty", bus.tx_empty, 1);
      chk("rst_ld_ack", bus.ld_tx_ack, 0);
      chk("rst_rx_empty", bus.rx_empty, 1);
      chk("rst_uld_ack", bus.uld_rx_ack, 0);
      chk("rst_rx_data", bus.rx_data, 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      tx_send(8'h55);
      repeat (3) begin
         d = 8'($urandom);
         tx_send(d);
      end

      rx_frame(8'hA3, 1'b1);
      rx_frame(8'h12, 1'b1);
      rx_unload();

      bus.rx_in = 1'b0;
      repeat (4) @(negedge clk);
      bus.rx_in = 1'b1;
      repeat (30) @(negedge clk);
      chk("glitch_rx_empty", bus.rx_empty, exp_empty);
      rx_frame(8'hFF, 1'b0);

      bus.rx_enable = 1'b0;
      rx_frame(8'($urandom), 1'b1);
      bus.rx_enable = 1'b1;
      repeat (4) @(negedge clk);

      repeat (6) begin
         d = 8'($urandom);
         rx_frame(d, ($urandom_range(0, 4) != 0));
         if ($urandom_range(0, 1) == 1) rx_unload();
      end

      bus.tx_enable = 1'b0;
      tx_load(8'h41);
      z = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.tx_out !== 1'b1) z++;
      end
      chk("txdis_line_idle", z, 0);
      chk("txdis_not_empty", bus.tx_empty, 0);
      bus.tx_enable = 1'b1;
      tx_capture(8'h41);

      fork
         tx_load(8'($urandom));
         begin
            z = 0;
            while (bus.tx_out !== 1'b0 && z < 80) begin
               @(negedge clk);
               z++;
            end
            chk("rstmid_start_seen", (z < 80), 1);
            repeat (50) @(negedge clk);
         end
      join
      #2 reset = 1'b1;
      #1;
      chk("rstmid_tx_out", bus.tx_out, 1);
      chk("rstmid_tx_empty", bus.tx_empty, 1);
      chk("rstmid_rx_data", bus.rx_data, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rstrel_tx_out", bus.tx_out, 1);
      chk("rstrel_tx_empty", bus.tx_empty, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
